dds_phase_gen: RTL and testbench
================================

Name: dds_phase_gen

Overview:
- Downstream consumer of the divided sample clock from the clock divider.
- Treats that clock as a data signal: synchronises it, edge-detects it, and on each rising edge advances a DDS phase accumulator by a frequency word.
- Produces a registered saw, triangle or square sample per tick for the DAC path.
- The frequency word is loaded through a valid/ready handshake and applied only at phase wrap, so frequency changes are glitch-free.

Parameters:
- ACC_W, 32, phase accumulator and frequency word width.
- OUT_W, 10, output sample width; phase index is acc[ACC_W-1 -: OUT_W].

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- sample_clk_in  input  1  divided sample clock from the divider, treated as data.
- enable  input  1  1 = ticks advance the accumulator.
- phase_clr  input  1  synchronous clear of the accumulator.
- fw_data  input  ACC_W  frequency word.
- fw_valid  input  1  fw_data is valid.
- fw_ready  output  1  pending slot is empty.
- wave_sel  input  2  0 = saw, 1 = triangle, 2 = square, 3 = off.
- duty  input  OUT_W  square threshold.
- wave_out  output  OUT_W  sample value.
- wave_valid  output  1  one-cycle pulse when wave_out updates.
- wrap_pulse  output  1  one-cycle pulse when the accumulator wraps.

Behaviour:
- One clock: clk. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Reset values:
  - acc = 0, fw_active = 0, pending empty, so fw_ready = 1.
  - wave_out = 0, wave_valid = 0, wrap_pulse = 0.
  - Sync flops s1, s2, s3 all reset to 1, so sample_clk_in held high across reset release produces no tick.
- Synchroniser:
  - s1 <= sample_clk_in, s2 <= s1, s3 <= s2; tick = s2 & ~s3.
  - A rise first sampled at edge E0 gives tick during the cycle after E1.
- Accumulator:
  - phase_clr has priority over tick: acc <= 0 on the next edge, with no wave_valid or wrap_pulse.
  - Else, if tick & enable: acc <= (acc + fw_active) mod 2^ACC_W; wrap_pulse <= carry-out.
  - Else acc holds.
- Output stage, registered one cycle after the acc update:
  - wave_out is computed from p = acc[ACC_W-1 -: OUT_W]; wave_valid pulses with it.
  - Latency: sample_clk_in rise sampled at E0 -> acc updates at E2 -> wave_out and wave_valid at E3.
- Waveforms:
  - saw = p.
  - triangle: t = (p << 1) truncated to OUT_W; output = p[OUT_W-1] ? ~t : t.
  - square: output = (p < duty) ? all-ones : 0, unsigned compare.
  - off: output = 0.
  - wave_sel and duty are sampled in the cycle the output is registered.
- Frequency word handshake:
  - Transfer occurs when fw_valid & fw_ready.
  - pending <= fw_data; pending_full = 1; fw_ready = ~pending_full, so it drops the cycle after capture.
- Pending -> fw_active transfer:
  - Occurs in the cycle after a tick whose addition produced carry-out.
  - The wrapping addition itself uses the old word.
  - Transfer is immediate (next edge) if fw_active == 0 or enable == 0.
  - The transfer clears pending_full.
  - No capture can coincide with a transfer, because fw_ready is 0 while pending is full.
- enable = 0:
  - Ticks are ignored; acc, wave_out and wrap_pulse are held or inactive; wave_valid stays 0.
- Reset mid-operation: all state returns to reset values next edge; any pending word is discarded.

Optional Feature:
- Macro: DDS_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11) is seeded 16'hACE1 on reset and steps once per accepted tick.
  - p = (acc + D)[ACC_W-1 -: OUT_W], where D is the LFSR zero-extended then masked to the low ACC_W-OUT_W bits.
  - This is truncation-spur dither. Latency is unchanged.
- Undefined: plain truncation; no LFSR logic is present.

Test Plan:
All cases use ACC_W = 32 and OUT_W = 10, with DDS_DITHER_EN undefined.
1. Reset/sync: hold sample_clk_in = 1 through rst and for 10 cycles after -> wave_valid stays 0, wave_out = 0, fw_ready = 1.
2. Saw: load fw 0x4000_0000, wave_sel = 0, 4 sample_clk rises -> wave_out 0x100, 0x200, 0x300, 0x000; wrap_pulse on the 4th tick only; each wave_valid comes 3 clk after the sampled rise.
3. Triangle: fw 0x2000_0000, wave_sel = 1 -> tick 1 p = 0x080 gives 0x100; tick 5 p = 0x280 gives 0x2FF.
4. Square: fw 0x4000_0000, duty = 0x200, wave_sel = 2 -> 0x3FF, 0x000, 0x000, 0x3FF for p = 0x100, 0x200, 0x300, 0x000.
5. Glitch-free update:
   - Setup: active 0x4000_0000; load 0x8000_0000 when acc = 0x4000_0000.
   - Expected: fw_ready = 0 until the wrap; steps remain 0x4000_0000 through the wrap, then 0x8000_0000 (p = 0x200, 0x000, ...).
6. enable = 0 with 3 ticks -> no wave_valid and acc unchanged. Then assert phase_clr together with a tick -> acc = 0, no wrap_pulse; the next enabled saw tick outputs p = fw[31:22].

Source files
------------

// File: rtl/dds_phase_gen.sv
// DDS phase generator: synchronises the divided sample clock, advances a phase
// accumulator per rising edge and emits saw/triangle/square samples.
// Optional macro DDS_DITHER_EN adds LFSR truncation dither to the phase index.
module dds_phase_gen #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_clk_in,
  input  logic             enable,
  input  logic             phase_clr,
  input  logic [ACC_W-1:0] fw_data,
  input  logic             fw_valid,
  output logic             fw_ready,
  input  logic [1:0]       wave_sel,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] wave_out,
  output logic             wave_valid,
  output logic             wrap_pulse
);

  localparam logic [1:0] SEL_SAW  = 2'd0;
  localparam logic [1:0] SEL_TRI  = 2'd1;
  localparam logic [1:0] SEL_SQR  = 2'd2;

  logic             s1, s2, s3;
  logic             tick;
  logic             advance;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fw_active;
  logic [ACC_W-1:0] pending;
  logic             pending_full;
  logic             upd_d;
  logic [ACC_W:0]   sum;
  logic [OUT_W-1:0] p;
  logic [OUT_W-1:0] t;
  logic [OUT_W-1:0] sample;

  // Sync flops reset high so a sample clock already high at reset release is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sample_clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick    = s2 & ~s3;
  assign advance = tick & enable & ~phase_clr;
  assign sum     = {1'b0, acc} + {1'b0, fw_active};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      wrap_pulse <= 1'b0;
      upd_d      <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      upd_d      <= advance;
      if (phase_clr) begin
        acc <= '0;
      end else if (advance) begin
        acc        <= sum[ACC_W-1:0];
        wrap_pulse <= sum[ACC_W];
      end
    end
  end

  // A new word waits in pending until the accumulator wraps, keeping phase continuous.
  assign fw_ready = ~pending_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      fw_active    <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (fw_valid && fw_ready) begin
      pending      <= fw_data;
      pending_full <= 1'b1;
    end else if (pending_full && (wrap_pulse || (fw_active == '0) || !enable)) begin
      fw_active    <= pending;
      pending_full <= 1'b0;
    end
  end

`ifdef DDS_DITHER_EN
  localparam logic [ACC_W-1:0] DITHER_MASK = {{OUT_W{1'b0}}, {(ACC_W-OUT_W){1'b1}}};

  logic [15:0]      lfsr;
  logic [ACC_W-1:0] dith_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign dith_sum = acc + (ACC_W'(lfsr) & DITHER_MASK);
  assign p        = dith_sum[ACC_W-1 -: OUT_W];
`else
  assign p = acc[ACC_W-1 -: OUT_W];
`endif

  always_comb begin
    t      = {p[OUT_W-2:0], 1'b0};
    sample = '0;
    case (wave_sel)
      SEL_SAW: sample = p;
      SEL_TRI: sample = p[OUT_W-1] ? ~t : t;
      SEL_SQR: sample = (p < duty) ? '1 : '0;
      default: sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_out   <= '0;
      wave_valid <= 1'b0;
    end else begin
      wave_valid <= upd_d;
      if (upd_d) begin
        wave_out <= sample;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen (ACC_W=32, OUT_W=10, no dither).
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_clk_in;
  logic        enable;
  logic        phase_clr;
  logic [31:0] fw_data;
  logic        fw_valid;
  logic        fw_ready;
  logic [1:0]  wave_sel;
  logic [9:0]  duty;
  logic [9:0]  wave_out;
  logic        wave_valid;
  logic        wrap_pulse;

  int num_checks = 0;
  int num_errors = 0;

  dds_phase_gen #(.ACC_W(32), .OUT_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_clk_in (sample_clk_in),
    .enable        (enable),
    .phase_clr     (phase_clr),
    .fw_data       (fw_data),
    .fw_valid      (fw_valid),
    .fw_ready      (fw_ready),
    .wave_sel      (wave_sel),
    .duty          (duty),
    .wave_out      (wave_out),
    .wave_valid    (wave_valid),
    .wrap_pulse    (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fw_valid = 1'b0; phase_clr = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sample_clk_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_fw(input string tag, input logic [31:0] word);
    int waited = 0;
    @(negedge clk);
    while (!fw_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " ready_before_load"}, 32'(fw_ready), 32'd1);
    fw_data  = word;
    fw_valid = 1'b1;
    @(negedge clk);
    fw_valid = 1'b0;
    checkOutput({tag, " ready_after_capture"}, 32'(fw_ready), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // One sample clock rise; captures outputs at E2, E3 and E4 relative to the first sampling edge E0.
  task automatic applyStimulus(input logic clr, output logic wrap_seen, output logic early_valid,
                               output logic valid_seen, output logic [9:0] out_seen,
                               output logic late_valid);
    @(negedge clk);
    sample_clk_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (clr) phase_clr = 1'b1;
    @(negedge clk);
    phase_clr   = 1'b0;
    wrap_seen   = wrap_pulse;
    early_valid = wave_valid;
    @(negedge clk);
    valid_seen = wave_valid;
    out_seen   = wave_out;
    sample_clk_in = 1'b0;
    @(negedge clk);
    late_valid = wave_valid;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_check(input string tag, input logic clr, input logic [9:0] exp_out,
                            input logic exp_wrap, input logic exp_valid);
    logic w, ev, v, lv;
    logic [9:0] o;
    applyStimulus(clr, w, ev, v, o, lv);
    checkOutput({tag, " wrap"}, 32'(w), 32'(exp_wrap));
    checkOutput({tag, " valid_E2"}, 32'(ev), 32'd0);
    checkOutput({tag, " valid_E3"}, 32'(v), 32'(exp_valid));
    checkOutput({tag, " valid_E4"}, 32'(lv), 32'd0);
    checkOutput({tag, " out"}, 32'(o), 32'(exp_out));
  endtask

  initial begin
    logic any_valid;
    logic any_wrap;
    logic [9:0] saw_exp [4];
    logic [9:0] sqr_exp [4];
    logic [9:0] tri_exp [5];
    logic       wrap_exp [4];
    saw_exp  = '{10'h100, 10'h200, 10'h300, 10'h000};
    sqr_exp  = '{10'h3FF, 10'h000, 10'h000, 10'h3FF};
    tri_exp  = '{10'h100, 10'h200, 10'h300, 10'h3FF, 10'h2FF};
    wrap_exp = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; sample_clk_in = 1'b1; enable = 1'b1; phase_clr = 1'b0;
    fw_data = '0; fw_valid = 1'b0; wave_sel = 2'd0; duty = 10'h200;

    // Reset with the sample clock held high: no spurious tick after release.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    any_valid = 1'b0;
    any_wrap  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_valid |= wave_valid;
      any_wrap  |= wrap_pulse;
    end
    checkOutput("reset valid", 32'(any_valid), 32'd0);
    checkOutput("reset wrap", 32'(any_wrap), 32'd0);
    checkOutput("reset out", 32'(wave_out), 32'd0);
    checkOutput("reset ready", 32'(fw_ready), 32'd1);

    $display("[TB] saw");
    do_reset();
    wave_sel = 2'd0;
    load_fw("saw", 32'h4000_0000);
    for (int i = 0; i < 4; i++)
      tick_check($sformatf("saw%0d", i + 1), 1'b0, saw_exp[i], wrap_exp[i], 1'b1);

    $display("[TB] triangle");
    do_reset();
    wave_sel = 2'd1;
    load_fw("tri", 32'h2000_0000);
    for (int i = 0; i < 5; i++)
      tick_check($sformatf("tri%0d", i + 1), 1'b0, tri_exp[i], 1'b0, 1'b1);

    $display("[TB] square");
    do_reset();
    wave_sel = 2'd2;
    duty = 10'h200;
    load_fw("sqr", 32'h4000_0000);
    for (int i = 0; i < 4; i++)
      tick_check($sformatf("sqr%0d", i + 1), 1'b0, sqr_exp[i], wrap_exp[i], 1'b1);

    $display("[TB] glitch-free update");
    do_reset();
    wave_sel = 2'd0;
    load_fw("gf0", 32'h4000_0000);
    tick_check("gf1", 1'b0, 10'h100, 1'b0, 1'b1);
    load_fw("gf_new", 32'h8000_0000);
    tick_check("gf2", 1'b0, 10'h200, 1'b0, 1'b1);
    checkOutput("gf ready held 2", 32'(fw_ready), 32'd0);
    tick_check("gf3", 1'b0, 10'h300, 1'b0, 1'b1);
    checkOutput("gf ready held 3", 32'(fw_ready), 32'd0);
    tick_check("gf4", 1'b0, 10'h000, 1'b1, 1'b1);
    checkOutput("gf ready after wrap", 32'(fw_ready), 32'd1);
    tick_check("gf5", 1'b0, 10'h200, 1'b0, 1'b1);
    tick_check("gf6", 1'b0, 10'h000, 1'b1, 1'b1);

    $display("[TB] enable and phase_clr");
    do_reset();
    wave_sel = 2'd0;
    load_fw("en0", 32'h4000_0000);
    tick_check("en1", 1'b0, 10'h100, 1'b0, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++)
      tick_check($sformatf("dis%0d", i + 1), 1'b0, 10'h100, 1'b0, 1'b0);
    enable = 1'b1;
    tick_check("en2", 1'b0, 10'h200, 1'b0, 1'b1);
    tick_check("clr", 1'b1, 10'h200, 1'b0, 1'b0);
    tick_check("after_clr", 1'b0, 10'h100, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got 0x1, expected 0x0");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
